neuron_array_scheduler: RTL and testbench

- Time-multiplexes one integrate-and-fire update datapath across N_NEURONS virtual neurons.
- Holds per-neuron membrane state and input-current accumulators.
- Sweeps all neurons once per timestep `tick`, and queues spike events (neuron index) in a small FIFO with a valid/ready drain.
- Sits between the synaptic-current source and the spike router.

---
 rtl/neuron_array_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_neuron_array_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_array_scheduler.sv
// Time-multiplexed integrate-and-fire scheduler: per-neuron state/accumulators, sweep FSM, spike FIFO.
// Optional membrane leak enabled by defining NEURON_SCHED_LEAK_EN.
module neuron_array_scheduler #(
  parameter int N_NEURONS  = 4,
  parameter int IDX_W      = 2,
  parameter int DATA_W     = 8,
  parameter int THRESH_RST = 200,
  parameter int FIFO_DEPTH = 4,
  parameter int LEAK_SHIFT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              cur_valid,
  output logic              cur_ready,
  input  logic [IDX_W-1:0]  cur_idx,
  input  logic [DATA_W-1:0] cur_data,
  input  logic              cfg_we,
  input  logic [DATA_W-1:0] cfg_thresh,
  output logic              busy,
  output logic              done,
  output logic              spk_valid,
  input  logic              spk_ready,
  output logic [IDX_W-1:0]  spk_idx,
  output logic              overflow,
  output logic              err
);

  localparam int FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = FIFO_AW + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);
`ifdef NEURON_SCHED_LEAK_EN
  localparam logic [DATA_W-1:0] LEAK_MASK = {DATA_W{1'b1}};
`else
  localparam logic [DATA_W-1:0] LEAK_MASK = {DATA_W{1'b0}};
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UPDATE = 2'd1,
    S_DONE   = 2'd2
  } fsm_t;

  fsm_t              fsm_r;
  logic [IDX_W-1:0]  ptr_r;
  logic [DATA_W-1:0] thresh_r;
  logic              busy_r, done_r, cur_ready_r, err_r, overflow_r;
  logic [DATA_W-1:0] v_r   [N_NEURONS];
  logic [DATA_W-1:0] acc_r [N_NEURONS];

  logic [IDX_W-1:0]   fifo_mem_r [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               spk_valid_r;
  logic [IDX_W-1:0]   spk_idx_r;

  logic [DATA_W-1:0]  u_s, i_s, leak_u_s, integ_s;
  logic               fire_s, pop_s, full_s, push_s, drop_s;
  logic [FIFO_AW-1:0] rd_nxt_s, wr_nxt_s;
  logic [CNT_W-1:0]   cnt_nxt_s;
  logic [IDX_W-1:0]   head_nxt_s;

  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[DATA_W]) begin
      return {DATA_W{1'b1}};
    end else begin
      return sum[DATA_W-1:0];
    end
  endfunction

  // Datapath for the neuron addressed by the sweep pointer; leak term is masked off when disabled.
  always_comb begin
    u_s      = v_r[ptr_r];
    i_s      = acc_r[ptr_r];
    leak_u_s = u_s - ((u_s >> LEAK_SHIFT) & LEAK_MASK);
    integ_s  = sat_add(leak_u_s, i_s);
    fire_s   = (fsm_r == S_UPDATE) && (u_s >= thresh_r);
  end

  // FIFO next-state; a pop frees the slot so a push on a full FIFO still lands.
  always_comb begin
    pop_s     = spk_valid_r && spk_ready;
    full_s    = (cnt_r == CNT_W'(FIFO_DEPTH));
    push_s    = fire_s && (!full_s || pop_s);
    drop_s    = fire_s && full_s && !pop_s;
    rd_nxt_s  = pop_s  ? (rd_ptr_r + FIFO_AW'(1'b1)) : rd_ptr_r;
    wr_nxt_s  = push_s ? (wr_ptr_r + FIFO_AW'(1'b1)) : wr_ptr_r;
    cnt_nxt_s = cnt_r + CNT_W'(push_s) - CNT_W'(pop_s);
    if (cnt_nxt_s == {CNT_W{1'b0}}) begin
      head_nxt_s = {IDX_W{1'b0}};
    end else if (push_s && (rd_nxt_s == wr_ptr_r)) begin
      head_nxt_s = ptr_r;
    end else begin
      head_nxt_s = fifo_mem_r[rd_nxt_s];
    end
  end

  // Sweep FSM with registered status outputs and threshold register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_r       <= S_IDLE;
      ptr_r       <= {IDX_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      cur_ready_r <= 1'b1;
      err_r       <= 1'b0;
      thresh_r    <= DATA_W'(THRESH_RST);
    end else begin
      case (fsm_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (cfg_we) begin
            thresh_r <= cfg_thresh;
          end
          if (tick) begin
            fsm_r       <= S_UPDATE;
            ptr_r       <= {IDX_W{1'b0}};
            busy_r      <= 1'b1;
            cur_ready_r <= 1'b0;
          end
        end
        S_UPDATE: begin
          ptr_r <= ptr_r + IDX_W'(1'b1);
          if (tick || cfg_we) begin
            err_r <= 1'b1;
          end
          if (ptr_r == LAST_IDX) begin
            fsm_r  <= S_DONE;
            done_r <= 1'b1;
          end
        end
        S_DONE: begin
          fsm_r       <= S_IDLE;
          done_r      <= 1'b0;
          busy_r      <= 1'b0;
          cur_ready_r <= 1'b1;
          if (tick || cfg_we) begin
            err_r <= 1'b1;
          end
        end
        default: begin
          fsm_r       <= S_IDLE;
          done_r      <= 1'b0;
          busy_r      <= 1'b0;
          cur_ready_r <= 1'b1;
        end
      endcase
    end
  end

  // Membrane and accumulator arrays: sweep updates, injections only land while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_NEURONS; k++) begin
        v_r[k]   <= {DATA_W{1'b0}};
        acc_r[k] <= {DATA_W{1'b0}};
      end
    end else if (fsm_r == S_UPDATE) begin
      v_r[ptr_r]   <= fire_s ? {DATA_W{1'b0}} : integ_s;
      acc_r[ptr_r] <= {DATA_W{1'b0}};
    end else if (cur_valid && cur_ready_r) begin
      acc_r[cur_idx] <= sat_add(acc_r[cur_idx], cur_data);
    end
  end

  // Spike FIFO storage, pointers and registered head/valid/overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        fifo_mem_r[k] <= {IDX_W{1'b0}};
      end
      wr_ptr_r    <= {FIFO_AW{1'b0}};
      rd_ptr_r    <= {FIFO_AW{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      spk_valid_r <= 1'b0;
      spk_idx_r   <= {IDX_W{1'b0}};
      overflow_r  <= 1'b0;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= ptr_r;
      end
      wr_ptr_r    <= wr_nxt_s;
      rd_ptr_r    <= rd_nxt_s;
      cnt_r       <= cnt_nxt_s;
      spk_valid_r <= (cnt_nxt_s != {CNT_W{1'b0}});
      spk_idx_r   <= head_nxt_s;
      overflow_r  <= overflow_r | drop_s;
    end
  end

  assign cur_ready = cur_ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign spk_valid = spk_valid_r;
  assign spk_idx   = spk_idx_r;
  assign overflow  = overflow_r;
  assign err       = err_r;

endmodule

// File: tb/tb_neuron_array_scheduler.sv
// Bench for neuron_array_scheduler: vector table plus spike scoreboard and corner-case sequences.
module tb_neuron_array_scheduler;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n, tick, cur_valid, cur_ready, cfg_we;
  logic [1:0] cur_idx;
  logic [7:0] cur_data, cfg_thresh;
  logic       busy, done, spk_valid, spk_ready, overflow, err;
  logic [1:0] spk_idx;

  int n_vec  = 0;
  int n_miss = 0;
  int exp_q[$];

  typedef struct {
    logic [1:0] idx;
    logic [7:0] d0, d1, thr, s1;
    logic       fire;
  } vec_t;
  vec_t vt[8];

  neuron_array_scheduler dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .cur_valid(cur_valid), .cur_ready(cur_ready), .cur_idx(cur_idx), .cur_data(cur_data),
    .cfg_we(cfg_we), .cfg_thresh(cfg_thresh),
    .busy(busy), .done(done),
    .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_idx(spk_idx),
    .overflow(overflow), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_leak(input logic [7:0] u);
`ifdef NEURON_SCHED_LEAK_EN
    return u - (u >> 3);
`else
    return u;
`endif
  endfunction

  // Scoreboard: every popped spike must match the oldest expected index.
  always begin
    @(negedge clk);
    #1;
    if (rst_n && spk_valid && spk_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL spk_unexpected: got idx %0d, want none", spk_idx);
      end else begin
        check("spk_idx", 32'(spk_idx), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0; tick = 1'b0; cur_valid = 1'b0; cfg_we = 1'b0; spk_ready = 1'b0;
    cur_idx = 2'd0; cur_data = 8'd0; cfg_thresh = 8'd0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic inject(input logic [1:0] idx, input logic [7:0] data);
    @(negedge clk);
    check("cur_ready_idle", 32'(cur_ready), 32'd1);
    cur_valid = 1'b1; cur_idx = idx; cur_data = data;
    @(negedge clk);
    cur_valid = 1'b0;
  endtask

  task automatic set_thr(input logic [7:0] v);
    @(negedge clk);
    cfg_we = 1'b1; cfg_thresh = v;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic run_sweep();
    int k;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check("busy_in_sweep", 32'(busy), 32'd1);
    check("cur_ready_busy", 32'(cur_ready), 32'd0);
    k = 0;
    while (k < 20 && done !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    check("done_latency", 32'(k), 32'(N));
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("busy_cleared", 32'(busy), 32'd0);
  endtask

  task automatic drain(input int cycles);
    spk_ready = 1'b1;
    repeat (cycles) @(negedge clk);
    spk_ready = 1'b0;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("spk_valid_drained", 32'(spk_valid), 32'd0);
  endtask

  initial begin
    vt[0] = '{idx: 2'd1, d0: 8'd120, d1: 8'd120, thr: 8'd200, s1: 8'd240, fire: 1'b1};
    vt[1] = '{idx: 2'd0, d0: 8'd200, d1: 8'd200, thr: 8'd200, s1: 8'd255, fire: 1'b1};
    vt[2] = '{idx: 2'd2, d0: 8'd50,  d1: 8'd60,  thr: 8'd200, s1: 8'd110, fire: 1'b0};
    vt[3] = '{idx: 2'd3, d0: 8'd100, d1: 8'd100, thr: 8'd200, s1: 8'd200, fire: 1'b1};
    vt[4] = '{idx: 2'd3, d0: 8'd100, d1: 8'd99,  thr: 8'd200, s1: 8'd199, fire: 1'b0};
    vt[5] = '{idx: 2'd1, d0: 8'd255, d1: 8'd0,   thr: 8'd255, s1: 8'd255, fire: 1'b1};
    vt[6] = '{idx: 2'd0, d0: 8'd10,  d1: 8'd20,  thr: 8'd30,  s1: 8'd30,  fire: 1'b1};
    vt[7] = '{idx: 2'd2, d0: 8'd1,   d1: 8'd2,   thr: 8'd4,   s1: 8'd3,   fire: 1'b0};

    // Reset state
    do_reset();
    check("rst_spk_valid", 32'(spk_valid), 32'd0);
    check("rst_spk_idx", 32'(spk_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cur_ready", 32'(cur_ready), 32'd1);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_thresh", 32'(dut.thresh_r), 32'd200);
    for (int i = 0; i < N; i++) check("rst_state", 32'(dut.v_r[i]), 32'd0);

    // Table: two injections, sweep, then a second sweep that may fire
    for (int v = 0; v < 8; v++) begin
      do_reset();
      if (vt[v].thr != 8'd200) set_thr(vt[v].thr);
      inject(vt[v].idx, vt[v].d0);
      inject(vt[v].idx, vt[v].d1);
      check("acc_sum", 32'(dut.acc_r[vt[v].idx]), 32'(vt[v].s1));
      run_sweep();
      check("state_sweep1", 32'(dut.v_r[vt[v].idx]), 32'(vt[v].s1));
      check("acc_cleared", 32'(dut.acc_r[vt[v].idx]), 32'd0);
      check("no_spike_sweep1", 32'(spk_valid), 32'd0);
      if (vt[v].fire) exp_q.push_back(int'(vt[v].idx));
      run_sweep();
      check("state_sweep2", 32'(dut.v_r[vt[v].idx]),
            vt[v].fire ? 32'd0 : 32'(exp_leak(vt[v].s1)));
      drain(6);
    end

    // Threshold zero: fill, overflow, then full-with-pop accepts pushes
    do_reset();
    set_thr(8'd0);
    for (int i = 0; i < N; i++) exp_q.push_back(i);
    run_sweep();
    check("fill_overflow", 32'(overflow), 32'd0);
    check("fill_valid", 32'(spk_valid), 32'd1);
    check("fill_head", 32'(spk_idx), 32'd0);
    run_sweep();
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_head", 32'(spk_idx), 32'd0);
    for (int i = 1; i < N; i++) exp_q.push_back(i);
    fork
      run_sweep();
      begin
        repeat (3) @(negedge clk);
        spk_ready = 1'b1;
      end
    join
    drain(12);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Tick and cfg_we mid-sweep
    do_reset();
    fork
      run_sweep();
      begin
        repeat (3) @(negedge clk);
        tick = 1'b1; cfg_we = 1'b1; cfg_thresh = 8'd5;
        @(negedge clk);
        tick = 1'b0; cfg_we = 1'b0;
      end
    join
    check("err_set", 32'(err), 32'd1);
    check("thresh_kept", 32'(dut.thresh_r), 32'd200);

    // Reset mid-sweep
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_cur_ready", 32'(cur_ready), 32'd1);
    check("midrst_spk_valid", 32'(spk_valid), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);

    // Leak (identity when the leak is disabled)
    do_reset();
    inject(2'd2, 8'd80);
    run_sweep();
    check("leak_pre", 32'(dut.v_r[2]), 32'd80);
    run_sweep();
    check("leak_post", 32'(dut.v_r[2]), 32'(exp_leak(8'd80)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
